// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-schedule state type, xtime and S-box table
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } kx_state_t;

    localparam int NR    = 10;
    localparam int KEY_W = 128;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES S-box byte lookup
//   i_byte : input byte
//   o_byte : SubBytes(i_byte)
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/key_expander.sv
// rtl/key_expander.sv - iterative AES-128 key schedule, one round key per clock into an 11-entry store
//   i_clk     : clock, rising edge
//   i_reset   : asynchronous active-low reset
//   i_start   : expansion request (ignored while expanding)
//   i_key_in  : cipher key, byte 0 in bits [127:120], word w0 in bits [127:96]
//   i_rd_idx  : round-key select (0..10 valid, 11..15 read as zero)
//   o_rd_key  : round key i_rd_idx, combinational from the store
//   o_busy    : expansion in progress
//   o_ready   : all 11 round keys valid
module key_expander
    import aes_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_key_in,
    input  logic [3:0]       i_rd_idx,
    output logic [KEY_W-1:0] o_rd_key,
    output logic             o_busy,
    output logic             o_ready
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    kx_state_t        r_state;
    kx_state_t        w_next_state;
    logic             w_load;
    logic [3:0]       r_rnd;
    logic [7:0]       r_rcon;
    logic [KEY_W-1:0] r_key [0:NR];

    logic [3:0]       w_prev_idx;
    logic [KEY_W-1:0] w_prev;
    logic [31:0]      w_w0, w_w1, w_w2, w_w3;
    logic [31:0]      w_rot, w_sub, w_t;
    logic [31:0]      w_n0, w_n1, w_n2, w_n3;

    // Previous round key; the guard only matters outside EXPAND where rnd may be 0.
    assign w_prev_idx = (r_rnd == 4'd0) ? 4'd0 : r_rnd - 4'd1;
    assign w_prev     = r_key[w_prev_idx];
    assign w_w0       = w_prev[127:96];
    assign w_w1       = w_prev[95:64];
    assign w_w2       = w_prev[63:32];
    assign w_w3       = w_prev[31:0];

    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    assign w_t = w_sub ^ {r_rcon, 24'h0};

    // Running XOR chain: each new word is the previous new word xor the old word.
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (i_start) begin
                    w_next_state = EXPAND;
                    w_load       = 1'b1;
                end
            end
            EXPAND: begin
                if (r_rnd == LAST_RND) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rnd  <= 4'd0;
            r_rcon <= 8'h01;
            for (int i = 0; i <= NR; i++) begin
                r_key[i] <= '0;
            end
        end else if (w_load) begin
            r_key[0] <= i_key_in;
            r_rnd    <= 4'd1;
            r_rcon   <= 8'h01;
        end else if (r_state == EXPAND) begin
            r_key[r_rnd] <= {w_n0, w_n1, w_n2, w_n3};
            r_rcon       <= xtime(r_rcon);
            r_rnd        <= r_rnd + 4'd1;
        end
    end

    assign o_rd_key = (i_rd_idx <= LAST_RND) ? r_key[i_rd_idx] : '0;
    assign o_busy   = (r_state == EXPAND);
    assign o_ready  = (r_state == DONE);

endmodule

// File: tb/tb_key_expander.sv
// tb/tb_key_expander.sv - directed self-checking bench for key_expander
module tb_key_expander;

    logic         i_clk;
    logic         i_reset;
    logic         i_start;
    logic [127:0] i_key_in;
    logic [3:0]   i_rd_idx;
    logic [127:0] o_rd_key;
    logic         o_busy;
    logic         o_ready;

    int errors;
    int n_checks;

    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_K2  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] JUNK_K   = 128'hdeadbeef0123456789abcdeffedcba98;

    key_expander dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (i_start),
        .i_key_in (i_key_in),
        .i_rd_idx (i_rd_idx),
        .o_rd_key (o_rd_key),
        .o_busy   (o_busy),
        .o_ready  (o_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic read_chk(input logic [3:0] idx, input logic [127:0] exp, input string tag);
        i_rd_idx = idx;
        #1;
        check(tag, o_rd_key, exp);
    endtask

    // Pulses start for one cycle from a negedge, counts busy cycles, optionally
    // re-pulses start with a junk key on the edge E4.
    task automatic run_expand(input logic [127:0] key, input bit repulse, input string tag);
        int cycles;
        @(negedge i_clk);
        i_start  = 1'b1;
        i_key_in = key;
        @(negedge i_clk);
        i_start  = 1'b0;
        i_key_in = JUNK_K;
        check({tag, "_ready_after_e0"}, 128'(o_ready), 128'd0);
        check({tag, "_busy_after_e0"},  128'(o_busy),  128'd1);
        read_chk(4'd0, key, {tag, "_key0_after_e0"});
        cycles = 0;
        while (o_busy && cycles < 30) begin
            cycles++;
            i_start = (repulse && cycles == 4);
            @(negedge i_clk);
        end
        i_start = 1'b0;
        check({tag, "_busy_cycles"}, 128'(cycles), 128'd10);
        check({tag, "_ready"},       128'(o_ready), 128'd1);
    endtask

    initial begin
        errors   = 0;
        n_checks = 0;
        i_reset  = 1'b0;
        i_start  = 1'b0;
        i_key_in = '0;
        i_rd_idx = 4'd0;
        repeat (3) @(negedge i_clk);

        check("rst_busy",  128'(o_busy),  128'd0);
        check("rst_ready", 128'(o_ready), 128'd0);
        read_chk(4'd0,  128'd0, "rst_key0");
        read_chk(4'd10, 128'd0, "rst_key10");

        i_reset = 1'b1;
        @(negedge i_clk);

        // FIPS key with a start re-pulse during expansion that must be ignored
        run_expand(FIPS_K0, 1'b1, "fips");
        read_chk(4'd0,  FIPS_K0,  "fips_k0");
        read_chk(4'd1,  FIPS_K1,  "fips_k1");
        read_chk(4'd2,  FIPS_K2,  "fips_k2");
        read_chk(4'd10, FIPS_K10, "fips_k10");
        for (int i = 11; i <= 15; i++) begin
            read_chk(4'(i), 128'd0, $sformatf("oor_idx%0d", i));
        end

        // Restart from DONE with the zero key
        run_expand(128'd0, 1'b0, "zero");
        read_chk(4'd0,  128'd0,   "zero_k0");
        read_chk(4'd1,  ZERO_K1,  "zero_k1");
        read_chk(4'd2,  ZERO_K2,  "zero_k2");
        read_chk(4'd10, ZERO_K10, "zero_k10");

        // Asynchronous reset just after E5 of an expansion
        @(negedge i_clk);
        i_start  = 1'b1;
        i_key_in = FIPS_K0;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        #1;
        check("arst_busy",  128'(o_busy),  128'd0);
        check("arst_ready", 128'(o_ready), 128'd0);
        for (int i = 0; i <= 10; i++) begin
            read_chk(4'(i), 128'd0, $sformatf("arst_key%0d", i));
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        repeat (15) @(negedge i_clk);
        check("idle_busy",  128'(o_busy),  128'd0);
        check("idle_ready", 128'(o_ready), 128'd0);
        read_chk(4'd0, 128'd0, "idle_key0");
        read_chk(4'd1, 128'd0, "idle_key1");

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/key_expander.md
# key_expander

Iterative AES-128 key-schedule unit that sits directly upstream of the main round-control FSM. On `start` it captures the 128-bit cipher key and computes round keys 1..10, one full round key per clock, into an internal 11-entry key store. The store is read combinationally by round index, driven by the FSM's 4-bit key-select output, so the datapath always sees the round key for the round in progress.

## Interface
- Parameters: none. Nr = 10 and the key width of 128 are fixed constants in the shared package.
- `clk`  in  1  main clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  expansion request, sampled on the rising edge.
- `key_in`  in  [0:127]  cipher key; bits [0:7] are byte 0; word w_i is bits [32i:32i+31].
- `rd_idx`  in  [0:3]  round-key select; connects to the FSM's `keyInit`.
- `rd_key`  out  [0:127]  round key `rd_idx`, combinational from the store.
- `busy`  out  1  expansion in progress.
- `ready`  out  1  all 11 round keys are valid.

## Operation
- States: IDLE, EXPAND, DONE (enum `kx_state_t`).
- IDLE + `start`=1: store `key_in` as key 0; set `rnd`=1 and `rcon`=8'h01; go to EXPAND.
- EXPAND, each cycle, with key[rnd-1] = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - Write key[rnd] = {w0^t, w0^w1^t, w0^w1^w2^t, w0^w1^w2^w3^t}.
  - Update `rcon` = xtime(`rcon`), i.e. {rcon[1:7],0} ^ (rcon[0] ? 8'h1b : 0). This gives 01,02,04,08,10,20,40,80,1b,36.
  - Increment `rnd`. When `rnd`=10 is written, go to DONE.
- DONE: `ready`=1 and keys are held. `start`=1 restarts exactly as from IDLE: key 0 is overwritten and `ready` drops on that edge.
- `start` during EXPAND is ignored. No queuing and no error flag.
- `rd_key`:
  - `rd_idx` 0..10 returns the store entry, valid or not.
  - `rd_idx` 11..15 returns 128'h0.
  - A read of an index being written on the same edge returns the old value until that edge.
- `busy` = (state == EXPAND). `ready` = (state == DONE).
- `key_in` is sampled only on the start edge. Later changes have no effect.

## Timing
- Reset values:
  - state = IDLE, `busy` = 0, `ready` = 0.
  - `rnd` = 0, `rcon` = 8'h01.
  - All 11 store entries = 0, so `rd_key` = 0.
- Start sampled at edge E0 → key 0 is valid after E0 and `busy`=1.
- Key k is written at edge Ek (k = 1..10).
- After E10: `busy`=0, `ready`=1. Total latency is 10 cycles from the start edge to `ready`.
- The FSM must not assert its first round before `ready`. The FSM's own store/first-addround lead is 2 cycles; gating it with `ready` is the integrator's job, not this block's.
- Reset asserted mid-expansion clears everything immediately (asynchronously). Expansion resumes only on a new `start` after release.
- The critical path is one round: 4 S-box lookups, XOR-chained across 4 words.

## Structure
- `aes_pkg` contains:
  - `kx_state_t`, `NR` = 10, `KEY_W` = 128.
  - `function xtime(byte)`.
  - `SBOX` constant table (256×8), shared with the round datapath's SubBytes.
- Sub-module `aes_sbox`: combinational 8-bit to 8-bit lookup from `aes_pkg::SBOX`, instantiated 4× for SubWord.
- `key_expander` contains the FSM, the `rnd`/`rcon` registers, the 11×128 store, and the round-key combinational logic.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, one-cycle `start`:
  - `busy` is high exactly 10 cycles, then `ready`.
  - rd_idx=1 → a0fafe1788542cb123a339392a6c7605.
  - rd_idx=10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_idx=0 → the key itself.
- All-zero key:
  - rd_idx=1 → 62636363626363636263636362636363.
  - rd_idx=10 → b4ef5bcb3e92e21123e951cf6f8f188e.
- Re-pulse `start` with a different key at E4 → ignored; the results match the first key.
- From DONE, `start` with the zero key after the FIPS key:
  - `ready` drops at the start edge.
  - The zero-key values appear after 10 cycles.
  - key 0 is updated at E0.
- Drive `reset`=0 at E5 of an expansion:
  - `busy`/`ready` go to 0 immediately and all `rd_key` reads are 0.
  - After release with no `start`, the block stays IDLE.
- After `ready`, sweep `rd_idx` 11..15 → `rd_key` = 0 in every case.
